// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with a 2-entry skid buffer
// Extension and pc+imm are computed at the input; main/skid registers hold {illegal, pc, target, imm}.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immext,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  localparam int EW = 3 * XLEN + 1;

  logic            s;
  logic [XLEN-1:0] imm_c;
  logic [XLEN-1:0] tgt_c;
  logic            ill_c;
  logic [EW-1:0]   new_ent;
  logic            unused_opcode;

  assign s             = instr[31];
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm_c = '0;
    ill_c = 1'b0;
    case (immsrc)
      3'b000: imm_c = {{(XLEN-12){s}}, instr[31:20]};
      3'b001: imm_c = {{(XLEN-12){s}}, instr[31:25], instr[11:7]};
      3'b010: imm_c = {{(XLEN-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011: imm_c = {{(XLEN-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      // sign-extend the 20-bit field first so RV64 gets copies of instr[31] above bit 31
      3'b100: imm_c = {{(XLEN-20){s}}, instr[31:12]} << 12;
      3'b101: imm_c = {{(XLEN-5){1'b0}}, instr[19:15]};
      3'b110: begin
        if (XLEN == 64) imm_c = {{(XLEN-6){1'b0}}, instr[25:20]};
        else            imm_c = {{(XLEN-5){1'b0}}, instr[24:20]};
      end
      default: ill_c = 1'b1;
    endcase
  end

  assign tgt_c   = pc_in + imm_c;
  assign new_ent = {ill_c, pc_in, tgt_c, imm_c};

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [EW-1:0] main_q, main_d;
  logic [EW-1:0] skid_q, skid_d;
  logic          accept;
  logic          main_free;

  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid_q || out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      // a full skid implies in_ready is low, so no new entry competes with it
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = new_ent;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_ent;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign {illegal, pc_out, target, immext} = main_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe at XLEN=32 and XLEN=64
// A queue model tracks buffered entries; directed vectors pin literal results.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic [31:0] pc32;
  logic [63:0] pc64;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32, tgt32, pco32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64, tgt64, pco64;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) u32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .pc_in(pc32),
    .out_valid(out_valid32), .out_ready(out_ready),
    .immext(imm32), .target(tgt32), .pc_out(pco32), .illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64)) u64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .pc_in(pc64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .immext(imm64), .target(tgt64), .pc_out(pco64), .illegal(ill64)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic        ill;
  } ent_t;

  ent_t q32[$];
  ent_t q64[$];

  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
    longint      v;
    logic [63:0] r;
    v = longint'($signed(ins));
    case (src)
      3'd0: r = 64'(v >>> 20);
      3'd1: r = 64'((v >>> 25) <<< 5) | 64'(ins[11:7]);
      3'd2: r = 64'((v >>> 31) <<< 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      3'd3: r = 64'((v >>> 31) <<< 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      3'd4: r = 64'((v >>> 12) <<< 12);
      3'd5: r = 64'(ins[19:15]);
      3'd6: r = (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
      default: r = 64'd0;
    endcase
    if (xlen == 32) r = r & 64'hFFFF_FFFF;
    return r;
  endfunction

  function automatic ent_t mk(input int xlen, input logic [63:0] pc);
    ent_t e;
    e.imm = ref_imm(instr, immsrc, xlen);
    e.tgt = pc + e.imm;
    if (xlen == 32) e.tgt = e.tgt & 64'hFFFF_FFFF;
    e.pc  = pc;
    e.ill = (immsrc == 3'b111);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: entries in flight, in arrival order
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q32.delete();
      q64.delete();
    end else begin
      automatic bit acc = in_valid && (q32.size() < 2);
      automatic bit drn = (q32.size() > 0) && out_ready;
      if (flush) begin
        q32.delete();
        q64.delete();
      end else begin
        if (drn) begin
          void'(q32.pop_front());
          void'(q64.pop_front());
        end
        if (acc) begin
          q32.push_back(mk(32, {32'd0, pc32}));
          q64.push_back(mk(64, pc64));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("in_ready32", 64'(in_ready32), 64'(q32.size() < 2));
      chk("out_valid32", 64'(out_valid32), 64'(q32.size() > 0));
      chk("in_ready64", 64'(in_ready64), 64'(q64.size() < 2));
      chk("out_valid64", 64'(out_valid64), 64'(q64.size() > 0));
      if (q32.size() > 0) begin
        chk("immext32", 64'(imm32), q32[0].imm);
        chk("target32", 64'(tgt32), q32[0].tgt);
        chk("pc_out32", 64'(pco32), q32[0].pc);
        chk("illegal32", 64'(ill32), 64'(q32[0].ill));
      end
      if (q64.size() > 0) begin
        chk("immext64", imm64, q64[0].imm);
        chk("target64", tgt64, q64[0].tgt);
        chk("pc_out64", pco64, q64[0].pc);
        chk("illegal64", 64'(ill64), 64'(q64[0].ill));
      end
    end
  end

  task automatic send_one(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] p32,
                          input logic [63:0] p64, input logic [31:0] ei32, input logic [31:0] et32,
                          input logic [63:0] ei64, input logic [63:0] et64, input logic eill);
    instr = ins; immsrc = src; pc32 = p32; pc64 = p64;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("lit_out_valid32", 64'(out_valid32), 64'd1);
    chk("lit_out_valid64", 64'(out_valid64), 64'd1);
    chk("lit_immext32", 64'(imm32), 64'(ei32));
    chk("lit_target32", 64'(tgt32), 64'(et32));
    chk("lit_immext64", imm64, ei64);
    chk("lit_target64", tgt64, et64);
    chk("lit_illegal32", 64'(ill32), 64'(eill));
    chk("lit_illegal64", 64'(ill64), 64'(eill));
    #1 in_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] p32, input logic [63:0] p64);
    bit acc = 1'b0;
    instr = ins; immsrc = src; pc32 = p32; pc64 = p64;
    in_valid = 1'b1;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready32;
      @(posedge clk); #2;
    end
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  logic [31:0] bp_ins [5] = '{32'h0050_0093, 32'h00A1_2223, 32'h7FFF_F0B7, 32'h00C0_006F, 32'h8000_0013};
  logic [2:0]  bp_src [5] = '{3'd0, 3'd1, 3'd4, 3'd3, 3'd0};

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid32"}, 64'(out_valid32), 64'd0);
    chk({tag, "_in_ready32"}, 64'(in_ready32), 64'd1);
    chk({tag, "_immext32"}, 64'(imm32), 64'd0);
    chk({tag, "_target32"}, 64'(tgt32), 64'd0);
    chk({tag, "_pc_out32"}, 64'(pco32), 64'd0);
    chk({tag, "_out_valid64"}, 64'(out_valid64), 64'd0);
    chk({tag, "_immext64"}, imm64, 64'd0);
    chk({tag, "_target64"}, tgt64, 64'd0);
    chk({tag, "_illegal64"}, 64'(ill64), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; immsrc = '0; pc32 = '0; pc64 = '0;
    #3;
    check_zero_outputs("reset");
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #2;

    send_one(32'hFFF0_0093, 3'd0, 32'h0, 64'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_one(32'hFE11_2E23, 3'd1, 32'h0, 64'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_one(32'hFE00_0CE3, 3'd2, 32'h100, 64'h100, 32'hFFFF_FFF8, 32'h0000_00F8, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0000_0000_00F8, 1'b0);
    send_one(32'hFF9F_F06F, 3'd3, 32'h4, 64'h4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_one(32'h8000_00B7, 3'd4, 32'h0, 64'h0, 32'h8000_0000, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send_one(32'h000F_8073, 3'd5, 32'h1000, 64'h1000, 32'h1F, 32'h101F, 64'h1F, 64'h101F, 1'b0);
    send_one(32'h03F0_0013, 3'd6, 32'h0, 64'h0, 32'h1F, 32'h1F, 64'h3F, 64'h3F, 1'b0);
    send_one(32'hFFFF_FFFF, 3'd7, 32'h200, 64'h200, 32'h0, 32'h200, 64'h0, 64'h200, 1'b1);
    @(posedge clk); #2;

    // backpressure: consumer stalls for three cycles while five entries stream in
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          push(bp_ins[i], bp_src[i], 32'h1000 + 32'(i * 4), 64'hFFFF_FFFF_FFFF_FFF0 + 64'(i * 4));
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #2;

    // flush with both entries full and a new input offered
    out_ready = 1'b0;
    push(32'h0010_0093, 3'd0, 32'h40, 64'h40);
    push(32'h0020_0093, 3'd0, 32'h44, 64'h44);
    instr = 32'h0030_0093; immsrc = 3'd0; pc32 = 32'h48; pc64 = 64'h48;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_out_valid32", 64'(out_valid32), 64'd0);
    chk("flush_in_ready32", 64'(in_ready32), 64'd1);
    chk("flush_out_valid64", 64'(out_valid64), 64'd0);
    #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // asynchronous reset in the middle of a transfer
    out_ready = 1'b0;
    push(32'hFFF0_0093, 3'd0, 32'h80, 64'h80);
    push(32'h0040_0093, 3'd0, 32'h84, 64'h84);
    out_ready = 1'b1; in_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
    send_one(32'hFE00_0CE3, 3'd2, 32'h100, 64'h100, 32'hFFFF_FFF8, 32'h0000_00F8, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0000_0000_00F8, 1'b0);
    repeat (2) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts a 32-bit instruction word, a 3-bit immediate-format select and the instruction's PC. It produces the sign- or zero-extended XLEN-bit immediate and the PC-relative target (pc + imm) one cycle later. Input and output use valid/ready handshakes with a 2-entry skid buffer, so the stage sustains one instruction per cycle under backpressure. It replaces the combinational extender between fetch and execute, adds RV64, CSR-immediate and shift-amount formats, and provides a flush for branch redirects.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  input word present
- in_ready  out  1  stage can accept an input this cycle
- instr  in  32  instruction; bits [6:0] are ignored
- immsrc  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR uimm), 110 SHAMT, 111 illegal
- pc_in  in  XLEN  instruction PC
- out_valid  out  1  output entry valid
- out_ready  in  1  consumer accepts the output
- immext  out  XLEN  extended immediate
- target  out  XLEN  pc + immext, modulo 2^XLEN
- pc_out  out  XLEN  PC carried alongside the entry
- illegal  out  1  entry had immsrc 111

## Operation
- Immediate formats, with s = instr[31] replicated to fill XLEN:
  - I: s, instr[31:20].
  - S: s, instr[31:25], instr[11:7].
  - B: s, instr[7], instr[30:25], instr[11:8], 0.
  - J: s, instr[19:12], instr[20], instr[30:21], 0.
  - U: s, instr[31:12], 12'h000. For XLEN=32 this is exactly instr[31:12]<<12; for XLEN=64 bits 63:32 are copies of instr[31].
  - Z: zero-extended instr[19:15].
  - SHAMT: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - 111: immext = 0, illegal = 1.
- Extension is computed combinationally at the input. The registered result is immext, target, pc_out and illegal.
- Buffer has two entries: main and skid.
  - An input is accepted on in_valid && in_ready.
  - in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- Accept rules:
  - Accept with main empty, or main draining this cycle (out_ready): the entry loads main.
  - Accept with main full and not draining: the entry loads skid; in_ready drops the next cycle.
  - Main drains while skid is full: skid moves to main, skid empties, in_ready returns high the next cycle.
- out_valid = main_valid. The output fields always reflect the main entry.
- Output fields hold stable while out_valid && !out_ready.
- flush: next cycle main_valid = skid_valid = 0 and in_ready = 1. Flush overrides any input accepted in the same cycle, which is dropped, and any drain.
- Ordering is strictly FIFO; no entry is ever dropped or duplicated except by flush.

## Timing
- Latency 1 cycle: an input accepted at edge N is on the outputs with out_valid = 1 after edge N.
- Throughput 1 entry/cycle while out_ready = 1.
- Reset (reset_n low, asynchronous): out_valid = 0, in_ready = 1, immext = target = pc_out = 0, illegal = 0, skid empty. Release is synchronous to the next edge.
- Reset asserted mid-transfer discards both entries immediately.
- Simultaneous drain of main and accept of an input with skid empty: the new entry loads main and out_valid stays 1.
- Simultaneous flush and reset_n low: reset wins.
- Arithmetic: target wraps modulo 2^XLEN; no overflow flag.

## Test plan
- XLEN=32, I, instr 0xFFF00093 -> immext 0xFFFFFFFF one cycle later, out_valid = 1.
- XLEN=32, S, instr 0xFE112E23 -> immext 0xFFFFFFFC.
- XLEN=32, B, instr 0xFE000CE3, pc 0x00000100 -> immext 0xFFFFFFF8, target 0x000000F8. J with pc 0x00000004 and offset -8 -> target 0xFFFFFFFC (wrap).
- XLEN=64:
  - U, instr 0x800000B7 -> immext 0xFFFFFFFF80000000.
  - Z, instr[19:15] = 5'h1F -> 0x1F.
  - SHAMT, instr[25:20] = 6'h3F -> 0x3F.
  - immsrc 111 -> immext 0, illegal = 1.
- Backpressure: stream 5 entries with out_ready low for 3 cycles -> in_ready low exactly one cycle after skid fills. All 5 entries emerge in order, unchanged, with no gaps once out_ready is high.
- Flush with both entries full and in_valid high -> next cycle out_valid = 0, in_ready = 1, no stale entry emitted. Assert reset_n low mid-stream -> outputs zero immediately.
